// File: rtl/dly_seq_pkg.sv
// Shared types and defaults for the DQS delay-line move sequencer.
// Imported by the sequencer top and its counter.
package dly_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_LDPULSE,
    ST_SETTLE,
    ST_FIN
  } state_e;

  localparam logic SEL_RX = 1'b0;
  localparam logic SEL_TX = 1'b1;

  localparam int DEF_MAX_TAP  = 127;
  localparam int DEF_MOVE_GAP = 4;
  localparam int DEF_SETTLE   = 8;

  localparam int TMR_W = 8;

endpackage

// File: rtl/dly_seq_cnt.sv
// Loadable down-counter with zero flag.
// Saturates at zero; load wins over decrement.
module dly_seq_cnt
  import dly_seq_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dly_line_move_seq.sv
// DQS delay-line move/load sequencer for the lane controller.
// Tracks RX/TX tap positions and paces MOVE/LOAD strobes.
module dly_line_move_seq
  import dly_seq_pkg::*;
#(
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = DEF_MAX_TAP,
  parameter int MOVE_GAP = DEF_MOVE_GAP,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_SEL,
  input  logic             REQ_LOAD,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_TAPS,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] TAP_POS_RX,
  output logic [TAP_W-1:0] TAP_POS_TX,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             ld_q, ld_d;
  logic             dir_q, dir_d;
  logic             pen_q, pen_d;
  logic             err_q, err_d;
  logic [TAP_W-1:0] rx_q, rx_d;
  logic [TAP_W-1:0] tx_q, tx_d;

  logic             tmr_ld, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             tap_ld, tap_dec, tap_zero;

  logic [TAP_W-1:0] cur_pos;
  logic [TAP_W:0]   sum_w;
  logic             rej;
  logic             oor;

  assign cur_pos = (REQ_SEL == SEL_TX) ? tx_q : rx_q;
  assign sum_w   = {1'b0, cur_pos} + {1'b0, REQ_TAPS};
  assign rej     = !REQ_LOAD &&
                   (REQ_DIR ? (sum_w > (TAP_W+1)'(MAX_TAP))
                            : (REQ_TAPS > cur_pos));
  assign oor     = (sel_q == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE
                                     : RX_DELAY_LINE_OUT_OF_RANGE;

  dly_seq_cnt #(.W(TMR_W)) u_tmr (
    .clk_i  (FAB_CLK),
    .rst_ni (ARST_N),
    .ld_i   (tmr_ld),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  dly_seq_cnt #(.W(TAP_W)) u_taps (
    .clk_i  (FAB_CLK),
    .rst_ni (ARST_N),
    .ld_i   (tap_ld),
    .val_i  (REQ_TAPS),
    .dec_i  (tap_dec),
    .zero_o (tap_zero)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ld_d    = ld_q;
    dir_d   = dir_q;
    pen_d   = pen_q;
    err_d   = err_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    tmr_dec = 1'b0;
    tap_ld  = 1'b0;
    tap_dec = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          sel_d  = REQ_SEL;
          ld_d   = REQ_LOAD;
          dir_d  = REQ_DIR;
          tap_ld = 1'b1;
          err_d  = rej;
          pen_d  = !rej;
          state_d = rej ? ST_FIN : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ld_q) begin
          state_d = ST_LDPULSE;
        end else if (tap_zero) begin
          state_d = ST_SETTLE;
          tmr_ld  = 1'b1;
          tmr_val = TMR_W'(SETTLE - 1);
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        tap_dec = 1'b1;
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(MOVE_GAP - 2);
        state_d = ST_GAP;
        if (sel_q == SEL_TX) begin
          tx_d = dir_q ? tx_q + TAP_W'(1) : tx_q - TAP_W'(1);
        end else begin
          rx_d = dir_q ? rx_q + TAP_W'(1) : rx_q - TAP_W'(1);
        end
      end
      ST_GAP: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (!oor && !tap_zero) begin
          state_d = ST_PULSE;
        end else begin
          err_d   = err_q | oor;
          state_d = ST_SETTLE;
          tmr_ld  = 1'b1;
          tmr_val = TMR_W'(SETTLE - 1);
        end
      end
      ST_LDPULSE: begin
        if (sel_q == SEL_TX) begin
          tx_d = '0;
        end else begin
          rx_d = '0;
        end
        state_d = ST_SETTLE;
        tmr_ld  = 1'b1;
        tmr_val = TMR_W'(SETTLE - 1);
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_FIN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FIN: begin
        pen_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      ld_q    <= 1'b0;
      dir_q   <= 1'b0;
      pen_q   <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      dir_q   <= dir_d;
      pen_q   <= pen_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
    end
  end

  // SEL/DIR only reach the pins for accepted, non-rejected requests
  assign REQ_READY            = (state_q == ST_IDLE);
  assign DONE                 = (state_q == ST_FIN);
  assign ERR                  = err_q;
  assign TAP_POS_RX           = rx_q;
  assign TAP_POS_TX           = tx_q;
  assign DELAY_LINE_SEL       = pen_q & sel_q;
  assign DELAY_LINE_DIRECTION = pen_q & dir_q;
  assign DELAY_LINE_MOVE      = (state_q == ST_PULSE);
  assign DELAY_LINE_LOAD      = (state_q == ST_LDPULSE);

endmodule

// File: tb/tb_dly_line_move_seq.sv
// Scoreboard bench for dly_line_move_seq.
// Driver predicts outcomes; negedge monitor checks strobes and DONE.
module tb_dly_line_move_seq;

  localparam int G    = 4;
  localparam int S    = 8;
  localparam int MAXT = 127;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_SEL = 1'b0;
  logic       REQ_LOAD = 1'b0;
  logic       REQ_DIR = 1'b0;
  logic [7:0] REQ_TAPS = '0;
  logic       DONE, ERR;
  logic [7:0] TAP_POS_RX, TAP_POS_TX;
  logic       DL_SEL, DL_LOAD, DL_DIR, DL_MOVE;
  logic       RX_OOR = 1'b0;
  logic       TX_OOR = 1'b0;

  always #5 clk = ~clk;

  dly_line_move_seq dut (
    .FAB_CLK                    (clk),
    .ARST_N                     (rst_n),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_SEL                    (REQ_SEL),
    .REQ_LOAD                   (REQ_LOAD),
    .REQ_DIR                    (REQ_DIR),
    .REQ_TAPS                   (REQ_TAPS),
    .DONE                       (DONE),
    .ERR                        (ERR),
    .TAP_POS_RX                 (TAP_POS_RX),
    .TAP_POS_TX                 (TAP_POS_TX),
    .DELAY_LINE_SEL             (DL_SEL),
    .DELAY_LINE_LOAD            (DL_LOAD),
    .DELAY_LINE_DIRECTION       (DL_DIR),
    .DELAY_LINE_MOVE            (DL_MOVE),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR)
  );

  typedef struct {
    int lat;
    int err;
    int rej;
    int sel;
    int dir;
    int moves;
    int loads;
    int rx;
    int tx;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pos[2];
  int   oor_k = 0;
  bit   oor_sel = 1'b0;
  bit   other_hi = 1'b0;
  int   mv_cnt = 0;
  int   ld_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Selected line's out-of-range rises once oor_k pulses were seen
  always @(posedge clk) begin
    #2;
    if (oor_sel) begin
      TX_OOR = (oor_k > 0) && (mv_cnt >= oor_k);
      RX_OOR = other_hi | 1'($urandom % 2);
    end else begin
      RX_OOR = (oor_k > 0) && (mv_cnt >= oor_k);
      TX_OOR = other_hi | 1'($urandom % 2);
    end
  end

  task automatic predict(int sel, int ld, int dir, int taps, int k,
                         output exp_t e);
    int p;
    int n;
    p = pos[sel];
    e = '{lat: 0, err: 0, rej: 0, sel: sel, dir: dir,
          moves: 0, loads: 0, rx: 0, tx: 0};
    if (ld != 0) begin
      pos[sel] = 0;
      e.lat    = 3 + S;
      e.loads  = 1;
    end else if (dir != 0 ? (p + taps > MAXT) : (taps > p)) begin
      e.rej = 1;
      e.err = 1;
      e.lat = 1;
    end else if (taps == 0) begin
      e.lat = 2 + S;
    end else begin
      n = (k >= 1 && k <= taps) ? k : taps;
      e.err    = (k >= 1 && k <= taps) ? 1 : 0;
      pos[sel] = (dir != 0) ? p + n : p - n;
      e.moves  = n;
      e.lat    = 2 + n * G + S;
    end
    e.rx = pos[0];
    e.tx = pos[1];
  endtask

  task automatic issue(int sel, int ld, int dir, int taps, int k);
    exp_t e;
    int   tgt;
    bit   got;
    @(posedge clk);
    #2;
    chk("ready_before_req", int'(REQ_READY), 1);
    predict(sel, ld, dir, taps, k, e);
    q.push_back(e);
    oor_sel   = 1'(sel);
    oor_k     = k;
    REQ_SEL   = 1'(sel);
    REQ_LOAD  = 1'(ld);
    REQ_DIR   = 1'(dir);
    REQ_TAPS  = 8'(taps);
    REQ_VALID = 1'b1;
    tgt = done_cnt + 1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      #2;
      if (done_cnt >= tgt) begin
        got = 1'b1;
      end else begin
        REQ_VALID = ($urandom % 3) == 0;
        REQ_SEL   = 1'($urandom);
        REQ_LOAD  = 1'($urandom);
        REQ_DIR   = 1'($urandom);
        REQ_TAPS  = 8'($urandom);
      end
    end
    REQ_VALID = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no DONE expected DONE within 3000 cycles");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  endtask

  bit   in_txn = 1'b0;
  int   acc = 0;
  int   mo;
  exp_t cur;
  exp_t me;
  bit   pin_bad = 1'b0;
  bit   tim_bad = 1'b0;
  bit   idle_bad = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 1'b0;
    end else if (in_txn) begin
      mo = cyc - acc;
      if (REQ_READY) pin_bad = 1'b1;
      if (cur.rej != 0) begin
        if (DL_SEL | DL_DIR | DL_MOVE | DL_LOAD) pin_bad = 1'b1;
      end else begin
        if (int'(DL_SEL) != cur.sel || int'(DL_DIR) != cur.dir)
          pin_bad = 1'b1;
        if (DL_MOVE) begin
          mv_cnt++;
          if (mo != 2 + (mv_cnt - 1) * G) tim_bad = 1'b1;
        end
        if (DL_LOAD) begin
          ld_cnt++;
          if (mo != 2) tim_bad = 1'b1;
        end
      end
      if (DONE) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          me = q.pop_front();
          chk("done_latency", mo, me.lat);
          chk("err", int'(ERR), me.err);
          chk("tap_pos_rx", int'(TAP_POS_RX), me.rx);
          chk("tap_pos_tx", int'(TAP_POS_TX), me.tx);
          chk("move_pulses", mv_cnt, me.moves);
          chk("load_pulses", ld_cnt, me.loads);
          chk("pins_sel_dir_ready", int'(pin_bad), 0);
          chk("strobe_timing", int'(tim_bad), 0);
          chk("idle_pins", int'(idle_bad), 0);
        end
        in_txn = 1'b0;
        done_cnt++;
      end
    end else begin
      if (DL_SEL | DL_DIR | DL_MOVE | DL_LOAD | DONE) idle_bad = 1'b1;
      if (REQ_VALID && REQ_READY) begin
        in_txn  = 1'b1;
        acc     = cyc;
        mv_cnt  = 0;
        ld_cnt  = 0;
        pin_bad = 1'b0;
        tim_bad = 1'b0;
        if (q.size() > 0) cur = q[0];
      end
    end
  end

  initial begin
    int sel, ld, dir, taps, k, r;
    pos[0] = 0;
    pos[1] = 0;
    #12;
    chk("rst_ready", int'(REQ_READY), 1);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_pos_rx", int'(TAP_POS_RX), 0);
    chk("rst_pos_tx", int'(TAP_POS_TX), 0);
    chk("rst_sel", int'(DL_SEL), 0);
    chk("rst_dir", int'(DL_DIR), 0);
    chk("rst_move", int'(DL_MOVE), 0);
    chk("rst_load", int'(DL_LOAD), 0);
    rst_n = 1'b1;

    issue(0, 1, 0, 0, 0);
    issue(1, 1, 0, 0, 0);
    issue(0, 0, 1, 3, 0);
    issue(1, 0, 1, 5, 0);
    issue(1, 0, 0, 6, 0);
    issue(1, 0, 1, 0, 0);
    issue(0, 0, 1, 123, 0);
    other_hi = 1'b1;
    issue(0, 0, 1, 1, 0);
    other_hi = 1'b0;
    issue(0, 0, 1, 1, 0);
    issue(1, 0, 1, 5, 2);

    // Abort a 10-tap RX decrement during its first GAP
    @(posedge clk);
    #2;
    oor_k     = 0;
    REQ_SEL   = 1'b0;
    REQ_LOAD  = 1'b0;
    REQ_DIR   = 1'b0;
    REQ_TAPS  = 8'd10;
    REQ_VALID = 1'b1;
    @(posedge clk);
    #2;
    REQ_VALID = 1'b0;
    @(posedge clk);
    #2;
    REQ_VALID = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_move", int'(DL_MOVE), 0);
    chk("arst_load", int'(DL_LOAD), 0);
    chk("arst_sel", int'(DL_SEL), 0);
    chk("arst_ready", int'(REQ_READY), 1);
    chk("arst_pos_rx", int'(TAP_POS_RX), 0);
    chk("arst_pos_tx", int'(TAP_POS_TX), 0);
    chk("arst_done", int'(DONE), 0);
    pos[0] = 0;
    pos[1] = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    REQ_VALID = 1'b0;
    rst_n = 1'b1;

    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom % 2);
      ld  = (($urandom % 6) == 0) ? 1 : 0;
      dir = int'($urandom % 2);
      r   = int'($urandom % 8);
      taps = (r == 0) ? int'($urandom_range(100, 140))
                      : int'($urandom % 7);
      k = 0;
      if (taps > 0 && ($urandom % 4) == 0)
        k = int'($urandom_range(1, taps + 1));
      issue(sel, ld, dir, taps, k);
    end

    repeat (3) @(posedge clk);
    chk("final_idle_pins", int'(idle_bad), 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
